// File: rtl/pe_east_link_arbiter.sv
// pe_east_link_arbiter: round-robin owner of the single east-bound PE link.
// A requester is granted the link for one burst. The burst ends on its
// req_last word or on its MAX_BURST-th word, and the link is then
// re-arbitrated after one idle cycle.
// Optional macro PE_ARB_TIMEOUT_EN: the burst is abandoned after IDLE_TIMEOUT
// consecutive cycles in which the owner does not present a word.
// Handshake: a word moves on a rising edge when req_valid[i] && req_ready[i].
// req_ready depends only on registered state. The PE side has no backpressure.
module pe_east_link_arbiter #(
   parameter int EAST_WIDTH   = 130,
   parameter int NUM_REQ      = 4,
   parameter int MAX_BURST    = 16,
   parameter int IDLE_TIMEOUT = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*EAST_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [EAST_WIDTH-1:0]         out_to_east,
   output logic                          ap_start,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          busy
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST) + 1;

   typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        owner_q, owner_d;
   logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0]      grant_q, grant_d;
   logic [CNT_W-1:0]        burst_cnt_q, burst_cnt_d;
   logic [EAST_WIDTH-1:0]   out_q, out_d;
   logic                    ap_start_q, ap_start_d;

   logic                    found;
   logic [IDX_W-1:0]        pick;
   logic [IDX_W-1:0]        next_ptr;
   logic [EAST_WIDTH-1:0]   sel_data;
   logic                    xfer;
   logic                    last_word;
   logic                    timeout;

   assign busy        = (state_q == ST_BURST);
   assign req_ready   = busy ? grant_q : '0;
   assign grant       = grant_q;
   assign out_to_east = out_q;
   assign ap_start    = ap_start_q;

   assign xfer      = busy && req_valid[owner_q];
   assign last_word = (burst_cnt_q == CNT_W'(MAX_BURST - 1));
   assign next_ptr  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

   // First valid requester searching upward from rr_ptr with wrap-around.
   always_comb begin
      logic [IDX_W:0] sum;
      found = 1'b0;
      pick  = '0;
      sum   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
         if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
         if (!found && req_valid[sum[IDX_W-1:0]]) begin
            found = 1'b1;
            pick  = sum[IDX_W-1:0];
         end
      end
   end

   // Data word of the current owner.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q == IDX_W'(i)) sel_data = req_data[i*EAST_WIDTH +: EAST_WIDTH];
      end
   end

`ifdef PE_ARB_TIMEOUT_EN
   logic [7:0] stall_cnt_q, stall_cnt_d;

   // Consecutive stall counter. The timeout fires on the edge ending the
   // IDLE_TIMEOUT-th stall cycle. A transfer in that cycle cancels it.
   always_comb begin
      stall_cnt_d = '0;
      if (busy && !xfer) stall_cnt_d = stall_cnt_q + 8'd1;
      timeout = busy && !xfer && (stall_cnt_q == 8'(IDLE_TIMEOUT - 1));
   end

   // Stall counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) stall_cnt_q <= '0;
      else       stall_cnt_q <= stall_cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   // Next-state and datapath: arbitrate in IDLE, forward words in BURST.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = grant_q;
      burst_cnt_d = burst_cnt_q;
      out_d       = out_q;
      ap_start_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               state_d     = ST_BURST;
               owner_d     = pick;
               grant_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
               burst_cnt_d = '0;
            end
         end
         ST_BURST: begin
            if (xfer) begin
               out_d       = sel_data;
               ap_start_d  = 1'b1;
               burst_cnt_d = burst_cnt_q + 1'b1;
            end
            if ((xfer && (req_last[owner_q] || last_word)) || timeout) begin
               state_d  = ST_IDLE;
               grant_d  = '0;
               rr_ptr_d = next_ptr;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         burst_cnt_q <= '0;
         out_q       <= '0;
         ap_start_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         burst_cnt_q <= burst_cnt_d;
         out_q       <= out_d;
         ap_start_q  <= ap_start_d;
      end
   end

endmodule

// File: tb/tb_pe_east_link_arbiter.sv
// Bench for pe_east_link_arbiter: randomized producers checked cycle by cycle
// against a burst-level reference model, plus directed scenarios.
module tb_pe_east_link_arbiter;
  localparam int W  = 130;
  localparam int N  = 4;
  localparam int MB = 16;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_last, req_ready, grant;
  logic [N*W-1:0] req_data;
  logic [W-1:0]   out_to_east;
  logic           ap_start, busy;

  // clock / reset
  always #5 clk = ~clk;

  pe_east_link_arbiter #(.EAST_WIDTH(W), .NUM_REQ(N), .MAX_BURST(MB), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .out_to_east(out_to_east),
    .ap_start(ap_start), .grant(grant), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: owner index (-1 = link idle), next search start, words
  // in this burst, consecutive stall cycles, expected registered outputs
  int           m_owner, m_ptr, m_cnt, m_stall;
  logic [W-1:0] m_out;
  logic         m_ap;
  logic [W-1:0] exp_q[$];

  // producers: valid probability, burst length (0 = never last), word budget
  // (-1 = unlimited), words left in current burst, current word
  int           act[N], blen[N], budget[N], left[N];
  logic [W-1:0] cur[N];

  logic [N-1:0] gq[$];
  logic [N-1:0] last_grant;
  int           ap_cnt;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] new_word(input int i);
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    r[W-1 -: 8] = 8'(i);
    return r[W-1:0];
  endfunction

  task automatic set_prod(input int i, input int a, input int bl, input int bud);
    act[i]    = a;
    blen[i]   = bl;
    budget[i] = bud;
    left[i]   = (bl == 0) ? -1 : bl;
    cur[i]    = new_word(i);
  endtask

  task automatic consume(input int i);
    if (budget[i] > 0) budget[i]--;
    if (left[i] > 0) begin
      left[i]--;
      if (left[i] == 0) left[i] = blen[i];
    end
    cur[i] = new_word(i);
  endtask

  // driver: random valid; req_last is random noise while valid is low
  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (budget[i] != 0) && ($urandom_range(99, 0) < act[i]);
      req_last[i]  = req_valid[i] ? (left[i] == 1) : 1'($urandom_range(1, 0));
      req_data[i*W +: W] = cur[i];
    end
  endtask

  // model: what the link must show after the coming edge
  task automatic model_step();
    logic lst;
    m_ap = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && req_valid[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_cnt   = 0;
          m_stall = 0;
        end
      end
    end else if (req_valid[m_owner]) begin
      lst   = req_last[m_owner];
      m_out = cur[m_owner];
      m_ap  = 1'b1;
      exp_q.push_back(cur[m_owner]);
      m_cnt++;
      m_stall = 0;
      consume(m_owner);
      if (lst || m_cnt == MB) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end else begin
`ifdef PE_ARB_TIMEOUT_EN
      m_stall++;
      if (m_stall == TO) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
`endif
    end
  endtask

  task automatic cycle();
    logic [N-1:0] g;
    drive_inputs();
    model_step();
    @(posedge clk);
    #1;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    check_eq("ap_start", W'(ap_start), W'(m_ap));
    check_eq("out_to_east", out_to_east, m_out);
    check_eq("grant", W'(grant), W'(g));
    check_eq("req_ready", W'(req_ready), W'(g));
    check_eq("busy", W'(busy), W'(m_owner >= 0));
    if (ap_start) begin
      ap_cnt++;
      if (exp_q.size() == 0) check_eq("sb_underflow", W'(ap_start), W'(0));
      else check_eq("sb_word", out_to_east, exp_q.pop_front());
    end
    if (grant != 0 && grant != last_grant) gq.push_back(grant);
    last_grant = grant;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_last  = '0;
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_stall = 0;
    m_out = '0; m_ap = 1'b0;
    exp_q.delete();
    last_grant = '0;
    for (int i = 0; i < N; i++) set_prod(i, 0, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] ord[5];
    ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
    ap_cnt = 0;
    #3;
    check_eq("rst_out", out_to_east, '0);
    check_eq("rst_ap", W'(ap_start), '0);
    check_eq("rst_grant", W'(grant), '0);
    check_eq("rst_busy", W'(busy), '0);
    check_eq("rst_ready", W'(req_ready), '0);
    do_reset();

    // single 3-word burst from requester 2, then rr_ptr must sit at 3
    set_prod(2, 100, 3, 3);
    cycle();
    check_eq("p1_grant", W'(grant), W'(4'b0100));
    repeat (8) cycle();
    set_prod(0, 100, 1, -1);
    set_prod(3, 100, 1, -1);
    cycle();
    check_eq("p1_rrptr", W'(grant), W'(4'b1000));

    // all four continuously valid, 2-word bursts: strict cyclic order
    do_reset();
    for (int i = 0; i < N; i++) set_prod(i, 100, 2, -1);
    gq.delete();
    repeat (16) cycle();
    for (int k = 0; k < 5; k++)
      check_eq("p2_order", W'((k < gq.size()) ? gq[k] : '0), W'(ord[k]));

    // 20-word stream without last: forced exit at 16, remainder after bubble
    do_reset();
    set_prod(1, 100, 0, 20);
    ap_cnt = 0;
    repeat (25) cycle();
    check_eq("p3_words", W'(ap_cnt), W'(20));

    // owner stalls 5 cycles mid-burst: ownership is kept
    do_reset();
    set_prod(0, 100, 0, -1);
    repeat (3) cycle();
    act[0] = 0;
    repeat (5) cycle();
    check_eq("p4_grant_held", W'(grant), W'(4'b0001));
    act[0] = 100;
    repeat (4) cycle();

`ifdef PE_ARB_TIMEOUT_EN
    // owner 2 stalls TO cycles while 3 waits: timeout hands link to 3
    do_reset();
    set_prod(2, 100, 0, -1);
    set_prod(3, 100, 0, -1);
    repeat (2) cycle();
    act[2] = 0;
    repeat (TO) cycle();
    check_eq("p5_exit", W'(grant), '0);
    cycle();
    check_eq("p5_next", W'(grant), W'(4'b1000));
`endif

    // randomized traffic in segments of varying activity and burst length
    do_reset();
    for (int seg = 0; seg < 6; seg++) begin
      for (int i = 0; i < N; i++) set_prod(i, $urandom_range(100, 20), $urandom_range(6, 0), -1);
      repeat (80) cycle();
    end

    // asynchronous reset between edges during word 2 of a burst
    do_reset();
    set_prod(0, 100, 6, -1);
    repeat (3) cycle();
    #3;
    reset = 1'b1;
    #1;
    check_eq("arst_out", out_to_east, '0);
    check_eq("arst_ap", W'(ap_start), '0);
    check_eq("arst_grant", W'(grant), '0);
    check_eq("arst_busy", W'(busy), '0);
    do_reset();
    set_prod(3, 100, 2, -1);
    set_prod(0, 100, 2, -1);
    cycle();
    check_eq("arst_regrant", W'(grant), W'(4'b0001));
    repeat (6) cycle();

    check_eq("sb_drain", W'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
